bus_toggle_monitor: RTL and testbench
=====================================

Name: bus_toggle_monitor

Overview:
Downstream observer for the bus-encoder instances (normal, bus-invert, transition-based, Gray, T0). Samples one encoded bus each clock and counts per-line bit transitions over a programmable window of cycles. Reports the total toggle count, the peak toggles seen in a single cycle, and a saturation flag through a valid/ready result port. It replaces offline VCD post-processing for switching-activity comparison between encodings.

Parameters:
W, 9, monitored bus width; 9 covers the encoders that add an INV/INC line.
CNT_W, 16, width of the total-toggle accumulator.
WIN_W, 16, width of the window-length input.

Ports:
ck  input  1  clock, rising edge active
rst  input  1  reset, asynchronous, active-high
bus_in  input  W  encoded bus under observation; sampled on every rising edge of ck
start  input  1  request to start a measurement window
win_len  input  WIN_W  number of transitions (cycle pairs) to count; latched when start is accepted
busy  output  1  high while a window is being counted
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_total  output  CNT_W  sum of toggles in the window, saturating
res_peak  output  clog2(W+1)  maximum toggles in any single cycle of the window
res_sat  output  1  res_total saturated during the window

Behaviour:
- Reset (async, rst=1): state IDLE. busy=0, res_valid=0, res_total=0, res_peak=0, res_sat=0. Internal prev, remaining and accumulators cleared. Asserting reset in any state aborts immediately; a partial result is never reported.
- FSM states: IDLE, COUNT, REPORT.
- IDLE: on an edge with start=1:
  - prev <= bus_in, which is the reference sample.
  - remaining <= win_len.
  - Accumulators cleared.
  - If win_len==0, go to REPORT with all zeros. Otherwise go to COUNT.
- COUNT, on each edge:
  - t = popcount(bus_in ^ prev).
  - total <= min(total+t, 2^CNT_W-1). sat <= sat | (overflow).
  - peak <= max(peak, t). prev <= bus_in. remaining <= remaining-1.
  - When remaining==1 at the edge, go to REPORT.
  - A window of N therefore compares N+1 consecutive samples. Latency from start to res_valid is N+1 edges, or 1 edge for N=0.
- start is ignored in COUNT.
- REPORT:
  - res_valid=1. res_* are registered and held stable until the handshake res_valid & res_ready completes.
  - On handshake the block returns to IDLE and res_valid drops the next cycle.
  - If start=1 on the handshake edge, the new window is accepted directly, exactly as from IDLE. This is back-to-back operation with no idle cycle.
- busy=1 exactly in COUNT.
- Outputs only change on the REPORT entry edge. res_* keep their last reported value until the next REPORT entry.
- Arithmetic:
  - Popcount is W-bit wide to clog2(W+1) bits, purely combinational.
  - The accumulator add is done at CNT_W+1 bits, then clamped.
- win_len is latched at acceptance; later changes do not affect the running window.

Decomposition:
- Package bus_mon_pkg:
  - function clog2.
  - Localparams PEAK_W = clog2(W+1) and SAT_MAX = 2^CNT_W-1.
  - FSM state encoding constants: IDLE=2'd0, COUNT=2'd1, REPORT=2'd2.
- One combinational sub-module, toggle_popcount (parameter W): inputs cur, prev; output cnt of width clog2(W+1). It is reused later by a per-line activity variant.
- The top holds the FSM, window counter and accumulators.

Test Plan:
- Settings: W=9, CNT_W=16, start pulsed for one cycle, res_ready=1 unless stated.
1. bus_in held 9'h000, win_len=4 -> res_valid 5 edges after start; res_total=0, res_peak=0, res_sat=0.
2. bus_in alternating 9'h000/9'h1FF every cycle, win_len=4 -> res_total=36, res_peak=9, res_sat=0.
3. bus_in sequence 0x000, 0x001, 0x003, 0x003, 0x0F3 with win_len=4 -> res_total=1+1+0+4=6, res_peak=4.
4. Instance with CNT_W=4, bus alternating 0x000/0x1FF, win_len=3 -> res_total=15, res_sat=1, res_peak=9.
5. win_len=0 -> res_valid one edge after start, all results zero. Then hold res_ready=0 for 5 cycles -> res_* and res_valid stable. Then res_ready=1 with start=1 and win_len=2 -> busy=1 the next cycle with no IDLE gap.
6. rst pulsed mid-COUNT with win_len=10 at the 4th edge -> busy=0 and res_valid=0 immediately (asynchronously). After release, start with win_len=1 -> a fresh result is produced with no carry-over.

Source files
------------

// File: rtl/bus_mon_pkg.sv
// Shared types and helpers for the bus toggle monitor and its popcount slice.
package bus_mon_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int BUS_W     = 9;
  localparam int CNT_W_DEF = 16;
  localparam int PEAK_W    = clog2(BUS_W + 1);
  localparam logic [CNT_W_DEF-1:0] SAT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/toggle_popcount.sv
// Number of lines that differ between two consecutive bus samples.
module toggle_popcount
  import bus_mon_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0]             cur,
  input  logic [W-1:0]             prev,
  output logic [clog2(W+1)-1:0]    cnt
);

  localparam int CW = clog2(W + 1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(cur[i] ^ prev[i]);
    end
  end

endmodule

// File: rtl/bus_toggle_monitor.sv
// Counts per-cycle bus toggles over a programmable window and reports
// total, single-cycle peak and saturation through a valid/ready port.
module bus_toggle_monitor
  import bus_mon_pkg::*;
#(
  parameter int W     = 9,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic [W-1:0]           bus_in,
  input  logic                   start,
  input  logic [WIN_W-1:0]       win_len,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CNT_W-1:0]       res_total,
  output logic [clog2(W+1)-1:0]  res_peak,
  output logic                   res_sat
);

  localparam int PW = clog2(W + 1);

  // Returns {overflow, clamped sum}; the add is one bit wider than the accumulator.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] acc,
                                             input logic [PW-1:0]    t);
    logic [CNT_W:0] s;
    s = {1'b0, acc} + (CNT_W+1)'(t);
    if (s[CNT_W]) begin
      s = {1'b1, {CNT_W{1'b1}}};
    end
    return s;
  endfunction

  state_t             state;
  logic [W-1:0]       prev;
  logic [WIN_W-1:0]   remaining;
  logic [CNT_W-1:0]   total;
  logic [PW-1:0]      peak;
  logic               sat;

  logic [PW-1:0]      t;
  logic [CNT_W:0]     sum;
  logic [PW-1:0]      nxt_peak;
  logic               accept;

  toggle_popcount #(.W(W)) u_pop (
    .cur  (bus_in),
    .prev (prev),
    .cnt  (t)
  );

  always_comb begin
    sum      = sat_add(total, t);
    nxt_peak = (t > peak) ? t : peak;
    accept   = start && ((state == IDLE) || ((state == REPORT) && res_ready));
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prev      <= '0;
      remaining <= '0;
      total     <= '0;
      peak      <= '0;
      sat       <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_total <= '0;
      res_peak  <= '0;
      res_sat   <= 1'b0;
    end else begin
      case (state)
        COUNT: begin
          total     <= sum[CNT_W-1:0];
          sat       <= sat | sum[CNT_W];
          peak      <= nxt_peak;
          prev      <= bus_in;
          remaining <= remaining - WIN_W'(1);
          if (remaining == WIN_W'(1)) begin
            state     <= REPORT;
            busy      <= 1'b0;
            res_valid <= 1'b1;
            res_total <= sum[CNT_W-1:0];
            res_peak  <= nxt_peak;
            res_sat   <= sat | sum[CNT_W];
          end
        end
        IDLE, REPORT: begin
          if ((state == REPORT) && res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
          // A start on the handshake edge is taken exactly as from IDLE.
          if (accept) begin
            prev      <= bus_in;
            remaining <= win_len;
            total     <= '0;
            peak      <= '0;
            sat       <= 1'b0;
            if (win_len == '0) begin
              state     <= REPORT;
              res_valid <= 1'b1;
              res_total <= '0;
              res_peak  <= '0;
              res_sat   <= 1'b0;
            end else begin
              state     <= COUNT;
              busy      <= 1'b1;
              res_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_toggle_monitor.sv
// Bench for bus_toggle_monitor: directed table, hand sequences, random windows vs. a model.
module tb_bus_toggle_monitor;

  localparam int W  = 9;
  localparam int PW = 4;

  logic          ck = 1'b0;
  logic          rst;
  logic          start, start4, res_ready;
  logic [W-1:0]  bus_in;
  logic [15:0]   win_len;

  logic          busy, res_valid, res_sat;
  logic [15:0]   res_total;
  logic [PW-1:0] res_peak;
  logic          busy4, res_valid4, res_sat4;
  logic [3:0]    res_total4;
  logic [PW-1:0] res_peak4;

  bus_toggle_monitor #(.W(W), .CNT_W(16), .WIN_W(16)) dut (
    .ck(ck), .rst(rst), .bus_in(bus_in), .start(start), .win_len(win_len),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_total(res_total), .res_peak(res_peak), .res_sat(res_sat)
  );

  bus_toggle_monitor #(.W(W), .CNT_W(4), .WIN_W(16)) dut4 (
    .ck(ck), .rst(rst), .bus_in(bus_in), .start(start4), .win_len(win_len),
    .busy(busy4), .res_valid(res_valid4), .res_ready(1'b1),
    .res_total(res_total4), .res_peak(res_peak4), .res_sat(res_sat4)
  );

  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] smp [0:63];

  typedef struct {
    int              n;
    logic [9*5-1:0]  s;
    int              tot;
    int              pk;
    bit              sat;
    string           name;
  } vec_t;

  vec_t tbl [0:4];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Expected results straight from the window definition: N transitions over N+1 samples.
  function automatic void model(input int n, input int cw, output int tot,
                                output int pk, output bit sat);
    longint s;
    longint maxv;
    int t;
    s  = 0;
    pk = 0;
    for (int k = 1; k <= n; k++) begin
      t = $countones(smp[k] ^ smp[k-1]);
      s += t;
      if (t > pk) pk = t;
    end
    maxv = (longint'(1) << cw) - 1;
    sat  = (s > maxv);
    tot  = sat ? int'(maxv) : int'(s);
  endfunction

  task automatic run_win(input bit u4, input int n, input int etot, input int epk,
                         input bit esat, input string nm);
    @(negedge ck);
    bus_in  = smp[0];
    win_len = 16'(n);
    if (u4) start4 = 1'b1; else start = 1'b1;
    @(posedge ck); #1;
    start  = 1'b0;
    start4 = 1'b0;
    for (int k = 1; k <= n; k++) begin
      chk({nm, ".busy"},  u4 ? busy4 : busy, 1);
      chk({nm, ".early"}, u4 ? res_valid4 : res_valid, 0);
      @(negedge ck);
      bus_in = smp[k];
      @(posedge ck); #1;
    end
    chk({nm, ".valid"}, u4 ? res_valid4 : res_valid, 1);
    chk({nm, ".idle"},  u4 ? busy4 : busy, 0);
    chk({nm, ".total"}, u4 ? 32'(res_total4) : 32'(res_total), etot);
    chk({nm, ".peak"},  u4 ? res_peak4 : res_peak, epk);
    chk({nm, ".sat"},   u4 ? res_sat4 : res_sat, esat);
    @(posedge ck); #1;
    chk({nm, ".drop"},  u4 ? res_valid4 : res_valid, 0);
  endtask

  initial begin
    int et, ep, n;
    bit es;

    rst = 1'b1; start = 1'b0; start4 = 1'b0; res_ready = 1'b1;
    bus_in = '0; win_len = '0;

    tbl[0] = '{n:4, s:{9'h000, 9'h000, 9'h000, 9'h000, 9'h000}, tot:0,  pk:0, sat:0, name:"quiet"};
    tbl[1] = '{n:4, s:{9'h000, 9'h1FF, 9'h000, 9'h1FF, 9'h000}, tot:36, pk:9, sat:0, name:"alt"};
    tbl[2] = '{n:4, s:{9'h0F3, 9'h003, 9'h003, 9'h001, 9'h000}, tot:6,  pk:4, sat:0, name:"seq"};
    tbl[3] = '{n:1, s:{9'h000, 9'h000, 9'h000, 9'h055, 9'h0AA}, tot:8,  pk:8, sat:0, name:"one"};
    tbl[4] = '{n:3, s:{9'h000, 9'h100, 9'h101, 9'h001, 9'h000}, tot:3,  pk:1, sat:0, name:"walk"};

    repeat (2) @(posedge ck);
    #1;
    chk("rst.busy",  busy, 0);
    chk("rst.valid", res_valid, 0);
    chk("rst.total", res_total, 0);
    chk("rst.peak",  res_peak, 0);
    chk("rst.sat",   res_sat, 0);
    @(negedge ck);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 5; k++) smp[k] = tbl[i].s[9*k +: 9];
      run_win(1'b0, tbl[i].n, tbl[i].tot, tbl[i].pk, tbl[i].sat, tbl[i].name);
    end

    // Narrow accumulator saturates.
    smp[0] = 9'h000; smp[1] = 9'h1FF; smp[2] = 9'h000; smp[3] = 9'h1FF;
    run_win(1'b1, 3, 15, 9, 1'b1, "sat4");

    // Zero-length window, stalled consumer, then back-to-back start on the handshake.
    @(negedge ck);
    win_len = '0; start = 1'b1; res_ready = 1'b0;
    @(posedge ck); #1;
    start = 1'b0;
    chk("zero.valid", res_valid, 1);
    chk("zero.total", res_total, 0);
    chk("zero.peak",  res_peak, 0);
    chk("zero.sat",   res_sat, 0);
    chk("zero.busy",  busy, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge ck);
      bus_in = 9'($urandom);
      @(posedge ck); #1;
      chk("hold.valid", res_valid, 1);
      chk("hold.total", res_total, 0);
      chk("hold.peak",  res_peak, 0);
    end
    @(negedge ck);
    res_ready = 1'b1; start = 1'b1; win_len = 16'd2; bus_in = 9'h000;
    @(posedge ck); #1;
    start = 1'b0;
    chk("b2b.busy",  busy, 1);
    chk("b2b.valid", res_valid, 0);
    @(negedge ck); bus_in = 9'h00F;
    @(posedge ck); #1;
    chk("b2b.busy2", busy, 1);
    @(negedge ck); bus_in = 9'h0FF;
    @(posedge ck); #1;
    chk("b2b.rvalid", res_valid, 1);
    chk("b2b.total",  res_total, 8);
    chk("b2b.peak",   res_peak, 4);
    @(posedge ck); #1;
    chk("b2b.drop",   res_valid, 0);

    // Asynchronous abort in the middle of a long window.
    @(negedge ck);
    bus_in = 9'h000; win_len = 16'd10; start = 1'b1;
    @(posedge ck); #1;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ck); bus_in = ~bus_in;
      @(posedge ck); #1;
    end
    chk("abort.pre", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("abort.busy",  busy, 0);
    chk("abort.valid", res_valid, 0);
    chk("abort.total", res_total, 0);
    @(negedge ck);
    rst = 1'b0;
    smp[0] = 9'h1FF; smp[1] = 9'h1FE;
    run_win(1'b0, 1, 1, 1, 1'b0, "fresh");

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1, 12);
      for (int k = 0; k <= n; k++) smp[k] = 9'($urandom);
      model(n, 16, et, ep, es);
      run_win(1'b0, n, et, ep, es, "rnd");
    end
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k <= n; k++) smp[k] = 9'($urandom);
      model(n, 4, et, ep, es);
      run_win(1'b1, n, et, ep, es, "rnd4");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
